// File: rtl/regfile_access_ctrl.sv
// Register file port arbiter: decode operand reads vs. pipeline write-backs, x0 hard-wired.
// Optional RF_BYPASS_EN forwards accepted write-backs into held operands.
module regfile_access_ctrl #(
  parameter int unsigned MAX_WB_STREAK = 4
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_rd_valid,
  output logic        o_rd_ready,
  input  logic [4:0]  i_rs1,
  input  logic [4:0]  i_rs2,
  output logic        o_op_valid,
  input  logic        i_op_ready,
  output logic [31:0] o_rs1_data,
  output logic [31:0] o_rs2_data,
  input  logic        i_wb_valid,
  output logic        o_wb_ready,
  input  logic [4:0]  i_wb_rd,
  input  logic [31:0] i_wb_data,
  output logic [4:0]  o_rf_read_register_1,
  output logic [4:0]  o_rf_read_register_2,
  output logic [4:0]  o_rf_write_register,
  output logic [31:0] o_rf_write_data,
  output logic        o_rf_we,
  input  logic [31:0] i_rf_read_data_1,
  input  logic [31:0] i_rf_read_data_2
);

  localparam int unsigned XLEN = 32;
  localparam int unsigned AW   = 5;
  localparam int unsigned SW   = 4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RDWAIT,
    S_OUT
  } state_t;

  state_t          state;
  logic [AW-1:0]   rs1_q;
  logic [AW-1:0]   rs2_q;
  logic [SW-1:0]   streak;
  logic [XLEN-1:0] op1_q;
  logic [XLEN-1:0] op2_q;

  logic wb_grant;
  logic rd_accept;
  logic wb_accept;
  logic streak_full;
  logic byp1;
  logic byp2;

  // Port arbitration; nothing is granted while reset is held
  always_comb begin
    streak_full = (streak == SW'(MAX_WB_STREAK));
    wb_grant    = 1'b0;
    o_rd_ready  = 1'b0;
    o_wb_ready  = 1'b0;
    if (!i_reset) begin
      if (state == S_IDLE) begin
        wb_grant   = i_wb_valid && !(streak_full && i_rd_valid);
        o_rd_ready = !wb_grant;
        o_wb_ready = wb_grant;
      end else begin
        o_wb_ready = 1'b1;
      end
    end
    rd_accept = o_rd_ready && i_rd_valid;
    wb_accept = o_wb_ready && i_wb_valid;
    o_rf_we   = wb_accept && (i_wb_rd != AW'(0));
  end

  assign o_rf_write_register  = i_wb_rd;
  assign o_rf_write_data      = i_wb_data;
  assign o_rf_read_register_1 = (state == S_IDLE) ? i_rs1 : rs1_q;
  assign o_rf_read_register_2 = (state == S_IDLE) ? i_rs2 : rs2_q;
  assign o_op_valid           = (state == S_OUT);
  assign o_rs1_data           = op1_q;
  assign o_rs2_data           = op2_q;

`ifdef RF_BYPASS_EN
  // o_rf_we already excludes x0, so a match here is always a real register
  assign byp1 = o_rf_we && (i_wb_rd == rs1_q);
  assign byp2 = o_rf_we && (i_wb_rd == rs2_q);
`else
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state  <= S_IDLE;
      rs1_q  <= '0;
      rs2_q  <= '0;
      streak <= '0;
      op1_q  <= '0;
      op2_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (rd_accept) begin
            rs1_q  <= i_rs1;
            rs2_q  <= i_rs2;
            streak <= '0;
            state  <= S_RDWAIT;
          end else if (!i_rd_valid) begin
            streak <= '0;
          end else if (o_rf_we && !streak_full) begin
            streak <= streak + SW'(1);
          end
        end
        S_RDWAIT: begin
          op1_q <= byp1 ? i_wb_data : ((rs1_q == AW'(0)) ? XLEN'(0) : i_rf_read_data_1);
          op2_q <= byp2 ? i_wb_data : ((rs2_q == AW'(0)) ? XLEN'(0) : i_rf_read_data_2);
          state <= S_OUT;
        end
        S_OUT: begin
          if (byp1) op1_q <= i_wb_data;
          if (byp2) op2_q <= i_wb_data;
          if (i_op_ready) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a registered-read register file model.
module tb_regfile_access_ctrl;

  logic        i_clk = 1'b0;
  logic        i_reset;
  logic        i_rd_valid;
  logic        o_rd_ready;
  logic [4:0]  i_rs1;
  logic [4:0]  i_rs2;
  logic        o_op_valid;
  logic        i_op_ready;
  logic [31:0] o_rs1_data;
  logic [31:0] o_rs2_data;
  logic        i_wb_valid;
  logic        o_wb_ready;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic [4:0]  o_rf_read_register_1;
  logic [4:0]  o_rf_read_register_2;
  logic [4:0]  o_rf_write_register;
  logic [31:0] o_rf_write_data;
  logic        o_rf_we;
  logic [31:0] i_rf_read_data_1;
  logic [31:0] i_rf_read_data_2;

  always #5 i_clk = ~i_clk;

  regfile_access_ctrl #(.MAX_WB_STREAK(4)) dut (
    .i_clk(i_clk), .i_reset(i_reset),
    .i_rd_valid(i_rd_valid), .o_rd_ready(o_rd_ready),
    .i_rs1(i_rs1), .i_rs2(i_rs2),
    .o_op_valid(o_op_valid), .i_op_ready(i_op_ready),
    .o_rs1_data(o_rs1_data), .o_rs2_data(o_rs2_data),
    .i_wb_valid(i_wb_valid), .o_wb_ready(o_wb_ready),
    .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
    .o_rf_read_register_1(o_rf_read_register_1),
    .o_rf_read_register_2(o_rf_read_register_2),
    .o_rf_write_register(o_rf_write_register),
    .o_rf_write_data(o_rf_write_data),
    .o_rf_we(o_rf_we),
    .i_rf_read_data_1(i_rf_read_data_1),
    .i_rf_read_data_2(i_rf_read_data_2)
  );

  // Register file model; x0 returns junk so the controller must force it to zero
  logic [31:0] rf_mem [32] = '{default: 32'h0};
  always @(posedge i_clk) begin
    if (o_rf_we) begin
      rf_mem[o_rf_write_register] <= o_rf_write_data;
    end else begin
      i_rf_read_data_1 <= (o_rf_read_register_1 == 5'd0) ? 32'hBAD0_0001 : rf_mem[o_rf_read_register_1];
      i_rf_read_data_2 <= (o_rf_read_register_2 == 5'd0) ? 32'hBAD0_0002 : rf_mem[o_rf_read_register_2];
    end
  end

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] v1;
    logic [31:0] v2;
  } exp_t;

  exp_t        sb_q [$];
  logic [31:0] shadow [32] = '{default: 32'h0};
  int          n_vec = 0;
  int          n_miss = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Handshake bookkeeping, evaluated mid-cycle with inputs settled
  task automatic monitor();
    exp_t        e;
    logic [31:0] e1;
    logic [31:0] e2;
    if (i_reset) begin
      sb_q.delete();
    end else begin
      if (o_op_valid && i_op_ready) begin
        if (sb_q.size() == 0) begin
          chk("sb_underflow", 32'(sb_q.size()), 32'd1);
        end else begin
          e = sb_q.pop_front();
`ifdef RF_BYPASS_EN
          e1 = shadow[e.rs1];
          e2 = shadow[e.rs2];
`else
          e1 = e.v1;
          e2 = e.v2;
`endif
          chk("sb_op1", o_rs1_data, e1);
          chk("sb_op2", o_rs2_data, e2);
        end
      end
      if (o_rd_ready && i_rd_valid) begin
        e.rs1 = i_rs1;
        e.rs2 = i_rs2;
        e.v1  = shadow[i_rs1];
        e.v2  = shadow[i_rs2];
        sb_q.push_back(e);
      end
      if (o_wb_ready && i_wb_valid && i_wb_rd != 5'd0) shadow[i_wb_rd] = i_wb_data;
    end
  endtask

  task automatic cyc();
    #1;
    monitor();
    @(negedge i_clk);
  endtask

  task automatic idle();
    i_rd_valid = 1'b0; i_rs1 = '0; i_rs2 = '0;
    i_wb_valid = 1'b0; i_wb_rd = '0; i_wb_data = '0;
    i_op_ready = 1'b1;
  endtask

  task automatic wb_once(input logic [4:0] rd, input logic [31:0] data);
    i_wb_valid = 1'b1; i_wb_rd = rd; i_wb_data = data;
    cyc();
    i_wb_valid = 1'b0;
  endtask

  task automatic do_read(input logic [4:0] a, input logic [4:0] b);
    bit acc = 1'b0;
    i_rd_valid = 1'b1; i_rs1 = a; i_rs2 = b;
    for (int i = 0; i < 10 && !acc; i++) begin
      #1;
      acc = o_rd_ready;
      cyc();
    end
    i_rd_valid = 1'b0;
    chk("rd_accept", 32'(acc), 32'd1);
  endtask

  task automatic wait_valid(output int lat);
    lat = 1;
    while (!o_op_valid && lat <= 10) begin
      cyc();
      lat++;
    end
    if (!o_op_valid) chk("op_valid_timeout", 32'(o_op_valid), 32'd1);
  endtask

  initial begin
    int lat;
    int we_cnt;
    logic [31:0] exp7;

    // Reset with requests pending: nothing may be granted or written
    idle();
    i_reset = 1'b1;
    i_rd_valid = 1'b1; i_rs1 = 5'd3;
    i_wb_valid = 1'b1; i_wb_rd = 5'd3; i_wb_data = 32'h3333_3333;
    #1;
    chk("rst_rd_ready", 32'(o_rd_ready), 32'd0);
    chk("rst_wb_ready", 32'(o_wb_ready), 32'd0);
    chk("rst_rf_we", 32'(o_rf_we), 32'd0);
    cyc();
    cyc();
    i_reset = 1'b0;
    idle();
    #1;
    chk("post_rst_op_valid", 32'(o_op_valid), 32'd0);
    chk("post_rst_op1", o_rs1_data, 32'd0);
    chk("post_rst_op2", o_rs2_data, 32'd0);
    chk("post_rst_rd_ready", 32'(o_rd_ready), 32'd1);

    // Write x5, count write-enable pulses
    i_wb_valid = 1'b1; i_wb_rd = 5'd5; i_wb_data = 32'hDEAD_BEEF;
    #1;
    we_cnt = int'(o_rf_we);
    cyc();
    idle();
    for (int i = 0; i < 3; i++) begin
      #1;
      we_cnt += int'(o_rf_we);
      cyc();
    end
    chk("x5_we_pulses", 32'(we_cnt), 32'd1);

    // Read rs1=5, rs2=0: two-cycle latency, x0 forced to zero
    do_read(5'd5, 5'd0);
    wait_valid(lat);
    chk("read_latency", 32'(lat), 32'd2);
    chk("x5_op1", o_rs1_data, 32'hDEAD_BEEF);
    chk("x5_op2_x0", o_rs2_data, 32'd0);
    cyc();

    // x0 write is consumed without a register file write
    i_wb_valid = 1'b1; i_wb_rd = 5'd0; i_wb_data = 32'h0000_1234;
    #1;
    chk("x0_wb_ready", 32'(o_wb_ready), 32'd1);
    chk("x0_rf_we", 32'(o_rf_we), 32'd0);
    cyc();
    idle();
    do_read(5'd0, 5'd5);
    wait_valid(lat);
    chk("x0_op1", o_rs1_data, 32'd0);
    cyc();

    // Write-back streak: four grants, then a forced read slot
    i_rd_valid = 1'b1; i_rs1 = 5'd10; i_rs2 = 5'd11;
    i_wb_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      i_wb_rd = 5'(10 + k); i_wb_data = 32'h1000 + 32'(k);
      #1;
      chk($sformatf("streak_wb_ready_%0d", k), 32'(o_wb_ready), (k < 4) ? 32'd1 : 32'd0);
      if (k == 4) chk("streak_rd_ready", 32'(o_rd_ready), 32'd1);
      cyc();
    end
    // Write to the just-latched rs1 during the capture cycle
    i_rd_valid = 1'b0;
    i_wb_rd = 5'd10; i_wb_data = 32'h2222;
    #1;
    chk("rdwait_wb_ready", 32'(o_wb_ready), 32'd1);
    cyc();
    idle();
    wait_valid(lat);
`ifdef RF_BYPASS_EN
    chk("rdwait_op1", o_rs1_data, 32'h2222);
`else
    chk("rdwait_op1", o_rs1_data, 32'h1000);
`endif
    cyc();

    // Held operand with a write to x7 while the consumer stalls
    wb_once(5'd7, 32'h11);
    idle();
    i_op_ready = 1'b0;
    do_read(5'd7, 5'd5);
    wait_valid(lat);
    for (int h = 0; h < 5; h++) begin
      if (h == 1) begin
        i_wb_valid = 1'b1; i_wb_rd = 5'd7; i_wb_data = 32'hA5A5_A5A5;
      end else begin
        i_wb_valid = 1'b0;
      end
      exp7 = 32'h11;
`ifdef RF_BYPASS_EN
      if (h >= 2) exp7 = 32'hA5A5_A5A5;
`endif
      #1;
      chk("hold_valid", 32'(o_op_valid), 32'd1);
      chk($sformatf("hold_op1_%0d", h), o_rs1_data, exp7);
      chk("hold_op2", o_rs2_data, 32'hDEAD_BEEF);
      cyc();
    end
    idle();
    cyc();

    // Reset while waiting on read data; the write offered in that cycle must drop
    do_read(5'd5, 5'd7);
    i_reset = 1'b1;
    i_wb_valid = 1'b1; i_wb_rd = 5'd9; i_wb_data = 32'h9999_9999;
    #1;
    chk("mid_rst_rf_we", 32'(o_rf_we), 32'd0);
    chk("mid_rst_wb_ready", 32'(o_wb_ready), 32'd0);
    cyc();
    i_reset = 1'b0;
    idle();
    #1;
    chk("mid_rst_op_valid", 32'(o_op_valid), 32'd0);
    chk("mid_rst_op1", o_rs1_data, 32'd0);
    chk("mid_rst_op2", o_rs2_data, 32'd0);
    do_read(5'd9, 5'd0);
    wait_valid(lat);
    chk("x9_unwritten", o_rs1_data, 32'd0);
    cyc();

    // Random traffic, scoreboard only
    for (int i = 0; i < 200; i++) begin
      i_rd_valid = 1'($urandom_range(0, 1));
      i_rs1      = 5'($urandom_range(0, 15));
      i_rs2      = 5'($urandom_range(0, 15));
      i_wb_valid = 1'($urandom_range(0, 1));
      i_wb_rd    = 5'($urandom_range(0, 15));
      i_wb_data  = $urandom;
      i_op_ready = ($urandom_range(0, 3) != 0);
      cyc();
    end
    idle();
    for (int i = 0; i < 5; i++) cyc();
    chk("sb_drained", 32'(sb_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
